// File: rtl/nf10_axi_lite_master.sv
// Single-outstanding AXI4-Lite master: turns a cmd/rsp stream into AXI-Lite reads/writes,
// with a per-transaction timeout so a hung slave cannot wedge the requester.
module nf10_axi_lite_master #(
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 32,
  parameter int C_TIMEOUT_CYCLES   = 256
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_rnw,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            rsp_timeout,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;
  localparam bit TO_EN = (C_TIMEOUT_CYCLES > 0);
  localparam int TW = TO_EN ? $clog2(C_TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TO_EN ? C_TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TMAX  = TW'(C_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP, RESP} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            abort;
  logic            cmd_ready_q, cmd_ready_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [AW-1:0]   araddr_q, araddr_d, awaddr_q, awaddr_d;
  logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic            rsp_valid_q, rsp_valid_d, rsp_to_q, rsp_to_d;
  logic [1:0]      rsp_resp_q, rsp_resp_d;

  logic accept, to_hit, aw_done, w_done;
  assign accept  = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  // >= rather than ==: a handshake on the last cycle can carry a saturated timer into the next phase
  assign to_hit  = TO_EN && (timer_q >= TLAST);
  assign aw_done = !awvalid_q || M_AXI_AWREADY;
  assign w_done  = !wvalid_q || M_AXI_WREADY;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      state_q <= IDLE;        timer_q <= '0;
      cmd_ready_q <= 1'b0;    rsp_valid_q <= 1'b0;
      arvalid_q <= 1'b0;      rready_q <= 1'b0;
      awvalid_q <= 1'b0;      wvalid_q <= 1'b0;     bready_q <= 1'b0;
      araddr_q <= '0;         awaddr_q <= '0;
      wdata_q <= '0;          wstrb_q <= '0;
      rdata_q <= '0;          rsp_resp_q <= 2'b00;  rsp_to_q <= 1'b0;
    end else begin
      state_q <= state_d;     timer_q <= timer_d;
      cmd_ready_q <= cmd_ready_d; rsp_valid_q <= rsp_valid_d;
      arvalid_q <= arvalid_d; rready_q <= rready_d;
      awvalid_q <= awvalid_d; wvalid_q <= wvalid_d; bready_q <= bready_d;
      araddr_q <= araddr_d;   awaddr_q <= awaddr_d;
      wdata_q <= wdata_d;     wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;     rsp_resp_q <= rsp_resp_d; rsp_to_q <= rsp_to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    timer_d = '0;
    case (state_q)
      IDLE:    if (accept) state_d = cmd_rnw ? RD_ADDR : WR_ADDR;
      RD_ADDR: if (M_AXI_ARREADY) state_d = RD_DATA;
               else if (to_hit) begin state_d = RESP; abort = 1'b1; end
      RD_DATA: if (M_AXI_RVALID) state_d = RESP;
               else if (to_hit) begin state_d = RESP; abort = 1'b1; end
      WR_ADDR: if (aw_done && w_done) state_d = WR_RESP;
               else if (to_hit) begin state_d = RESP; abort = 1'b1; end
      WR_RESP: if (M_AXI_BVALID) state_d = RESP;
               else if (to_hit) begin state_d = RESP; abort = 1'b1; end
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q inside {RD_ADDR, RD_DATA, WR_ADDR, WR_RESP})
      timer_d = (timer_q != TMAX) ? timer_q + TW'(1) : timer_q;
  end

  // Outputs are computed from the next state so every port comes straight from a flop
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    arvalid_d   = (state_d == RD_ADDR);
    rready_d    = (state_d == IDLE) || (state_d == RD_DATA);
    bready_d    = (state_d == IDLE) || (state_d == WR_RESP);
    rsp_valid_d = (state_d == RESP);
    awvalid_d   = ((state_q == IDLE) && (state_d == WR_ADDR)) ||
                  ((state_q == WR_ADDR) && (state_d == WR_ADDR) && awvalid_q && !M_AXI_AWREADY);
    wvalid_d    = ((state_q == IDLE) && (state_d == WR_ADDR)) ||
                  ((state_q == WR_ADDR) && (state_d == WR_ADDR) && wvalid_q && !M_AXI_WREADY);
    araddr_d = araddr_q; awaddr_d = awaddr_q; wdata_d = wdata_q; wstrb_d = wstrb_q;
    if (accept && cmd_rnw) araddr_d = cmd_addr;
    if (accept && !cmd_rnw) begin
      awaddr_d = cmd_addr; wdata_d = cmd_wdata; wstrb_d = cmd_wstrb;
    end
    rdata_d = rdata_q; rsp_resp_d = rsp_resp_q; rsp_to_d = rsp_to_q;
    if (abort) begin
      rdata_d = '0; rsp_resp_d = 2'b10; rsp_to_d = 1'b1;
    end else if ((state_q == RD_DATA) && M_AXI_RVALID) begin
      rdata_d = M_AXI_RDATA; rsp_resp_d = M_AXI_RRESP; rsp_to_d = 1'b0;
    end else if ((state_q == WR_RESP) && M_AXI_BVALID) begin
      rdata_d = '0; rsp_resp_d = M_AXI_BRESP; rsp_to_d = 1'b0;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign rsp_timeout   = rsp_to_q;
  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
endmodule

// File: tb/tb_nf10_axi_lite_master.sv
// Bench for nf10_axi_lite_master: vector table driven through a reactive slave, plus
// cycle-exact sequences for latency, write channel split, timeout, SLVERR hold, reset and back-to-back.
module tb_nf10_axi_lite_master;
  logic        clk = 1'b0;
  logic        rstn;
  logic        cmd_valid, cmd_ready, cmd_rnw;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;

  nf10_axi_lite_master #(.C_M_AXI_DATA_WIDTH(32), .C_M_AXI_ADDR_WIDTH(32), .C_TIMEOUT_CYCLES(16)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rnw(cmd_rnw), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rnw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  strb;
    int          w1;   // ARREADY or AWREADY wait
    int          w2;   // WREADY wait
    int          w3;   // RVALID or BVALID wait
    logic [31:0] sdata;
    logic [1:0]  sresp;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    bit          exp_to;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic slave_idle();
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n, arw, aww, ww, rw, bw;
    bit acc, r_pend, b_pend, aw_ok, w_ok, got, arh, awh, wh, rh, bh;
    logic [31:0] g_rdata;
    logic [1:0]  g_resp;
    logic        g_to;
    arw = 0; aww = 0; ww = 0; rw = 0; bw = 0;
    r_pend = 0; b_pend = 0; aw_ok = 0; w_ok = 0; got = 0;
    g_rdata = 0; g_resp = 0; g_to = 0;
    cmd_valid = 1; cmd_rnw = v.rnw; cmd_addr = v.addr; cmd_wdata = v.wd; cmd_wstrb = v.strb;
    rsp_ready = 1;
    acc = 0;
    for (n = 0; n < 10 && !acc; n++) begin
      acc = cmd_ready;
      tick();
    end
    cmd_valid = 0;
    chk($sformatf("v%0d accept", idx), {31'b0, acc}, 32'd1);
    for (n = 0; n < 40 && !got; n++) begin
      arready = arvalid && (arw >= v.w1);  if (arvalid) arw++;
      awready = awvalid && (aww >= v.w1);  if (awvalid) aww++;
      wready  = wvalid && (ww >= v.w2);    if (wvalid) ww++;
      rvalid  = r_pend && (rw >= v.w3);    if (r_pend) rw++;
      bvalid  = b_pend && (bw >= v.w3);    if (b_pend) bw++;
      rdata = rvalid ? v.sdata : 32'h0;  rresp = rvalid ? v.sresp : 2'b00;
      bresp = bvalid ? v.sresp : 2'b00;
      if (rsp_valid) begin
        got = 1; g_rdata = rsp_rdata; g_resp = rsp_resp; g_to = rsp_timeout;
      end
      arh = arvalid && arready; awh = awvalid && awready; wh = wvalid && wready;
      rh = rvalid && rready;    bh = bvalid && bready;
      if (arh) chk($sformatf("v%0d araddr", idx), araddr, v.addr);
      if (awh) chk($sformatf("v%0d awaddr", idx), awaddr, v.addr);
      if (wh) chk($sformatf("v%0d wdata", idx), wdata, v.wd);
      tick();
      if (arh) r_pend = 1;
      if (rh) r_pend = 0;
      if (awh) aw_ok = 1;
      if (wh) w_ok = 1;
      if (aw_ok && w_ok && !b_pend && !bh && bw == 0) b_pend = 1;
      if (bh) b_pend = 0;
    end
    slave_idle();
    chk($sformatf("v%0d rsp_seen", idx), {31'b0, got}, 32'd1);
    chk($sformatf("v%0d rdata", idx), g_rdata, v.exp_rdata);
    chk($sformatf("v%0d resp", idx), {30'b0, g_resp}, {30'b0, v.exp_resp});
    chk($sformatf("v%0d timeout", idx), {31'b0, g_to}, {31'b0, v.exp_to});
  endtask

  vec_t vecs[9];

  initial begin
    logic [31:0] addrs[3];
    logic [31:0] raddr;
    int idx, nrsp, overlap;
    bit r_pend, acc, arh, rh;

    vecs[0] = '{1'b1, 32'h4,  32'h0,        4'h0, 0,  0, 0,  32'h0000_00A5, 2'b00, 32'h0000_00A5, 2'b00, 1'b0};
    vecs[1] = '{1'b1, 32'h8,  32'h0,        4'h0, 2,  0, 3,  32'hCAFE_F00D, 2'b01, 32'hCAFE_F00D, 2'b01, 1'b0};
    vecs[2] = '{1'b0, 32'h20, 32'h1234_5678, 4'h3, 0, 3, 1,  32'h0,         2'b00, 32'h0,         2'b00, 1'b0};
    vecs[3] = '{1'b0, 32'h24, 32'hA5A5_5A5A, 4'hF, 4, 0, 0,  32'h0,         2'b11, 32'h0,         2'b11, 1'b0};
    vecs[4] = '{1'b1, 32'hC,  32'h0,        4'h0, 0,  0, 99, 32'hFFFF_FFFF, 2'b00, 32'h0,         2'b10, 1'b1};
    vecs[5] = '{1'b0, 32'h28, 32'h0BAD_F00D, 4'hF, 99, 0, 0, 32'h0,         2'b00, 32'h0,         2'b10, 1'b1};
    vecs[6] = '{1'b1, 32'h30, 32'h0,        4'h0, 99, 0, 0,  32'h1111_1111, 2'b00, 32'h0,         2'b10, 1'b1};
    // last-cycle handshake beats the timeout; one cycle later it does not
    vecs[7] = '{1'b1, 32'h34, 32'h0,        4'h0, 5,  0, 9,  32'h7777_0007, 2'b00, 32'h7777_0007, 2'b00, 1'b0};
    vecs[8] = '{1'b1, 32'h38, 32'h0,        4'h0, 5,  0, 10, 32'h8888_0008, 2'b00, 32'h0,         2'b10, 1'b1};

    rstn = 0; cmd_valid = 0; cmd_rnw = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 0;
    slave_idle();
    tick(); tick();
    chk("rst cmd_ready", {31'b0, cmd_ready}, 0);
    chk("rst valids", {26'b0, arvalid, awvalid, wvalid, rsp_valid, rready, bready}, 0);
    chk("rst rsp", {rsp_rdata[29:0], rsp_resp}, 0);
    chk("rst addr", awaddr | araddr | wdata, 0);
    rstn = 1;
    tick();
    chk("idle cmd_ready", {29'b0, cmd_ready, rready, bready}, 32'h7);

    // zero-wait read of DATE
    cmd_valid = 1; cmd_rnw = 1; cmd_addr = 32'h0; arready = 1;
    tick();
    cmd_valid = 0;
    chk("t1 c1 arvalid", {31'b0, arvalid}, 1);
    chk("t1 c1 araddr", araddr, 32'h0);
    chk("t1 c1 cmd_ready", {31'b0, cmd_ready}, 0);
    tick();
    chk("t1 c2 arvalid/rready", {30'b0, arvalid, rready}, 32'h1);
    rvalid = 1; rdata = 32'h2013_0515; rresp = 2'b00;
    tick();
    slave_idle();
    chk("t1 c3 rsp_valid", {31'b0, rsp_valid}, 1);
    chk("t1 c3 rdata", rsp_rdata, 32'h2013_0515);
    chk("t1 c3 resp/to", {29'b0, rsp_resp, rsp_timeout}, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("t1 c4 idle", {30'b0, rsp_valid, cmd_ready}, 32'h1);

    // write with split AW/W handshakes
    cmd_valid = 1; cmd_rnw = 0; cmd_addr = 32'h10; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    tick();
    cmd_valid = 0;
    chk("t2 c1 aw/w valid", {30'b0, awvalid, wvalid}, 32'h3);
    chk("t2 c1 awaddr", awaddr, 32'h10);
    chk("t2 c1 wdata", wdata, 32'hDEAD_BEEF);
    chk("t2 c1 wstrb/bready", {27'b0, wstrb, bready}, {27'b0, 4'hF, 1'b0});
    awready = 1;
    tick();
    awready = 0;
    chk("t2 c2 aw/w valid", {30'b0, awvalid, wvalid}, 32'h1);
    tick();
    chk("t2 c3 wvalid/bready", {30'b0, wvalid, bready}, 32'h2);
    tick();
    chk("t2 c4 wvalid/wdata", {wvalid, wdata[30:0]}, {1'b1, 31'h5EAD_BEEF});
    wready = 1;
    tick();
    wready = 0;
    chk("t2 c5 wvalid/bready", {30'b0, wvalid, bready}, 32'h1);
    bvalid = 1; bresp = 2'b00;
    tick();
    slave_idle();
    chk("t2 rsp", {28'b0, rsp_valid, rsp_resp, rsp_timeout}, 32'h8);
    chk("t2 rdata/bready", {rsp_rdata[30:0], bready}, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // read timeout, then a late RVALID drained in IDLE
    cmd_valid = 1; cmd_rnw = 1; cmd_addr = 32'h40; arready = 1;
    tick();
    cmd_valid = 0;
    for (int c = 1; c <= 16; c++) begin
      if (c == 2) arready = 0;
      if (c == 1 || c == 16) chk($sformatf("t3 c%0d no rsp", c), {31'b0, rsp_valid}, 0);
      tick();
    end
    chk("t3 rsp_valid", {31'b0, rsp_valid}, 1);
    chk("t3 resp/to", {29'b0, rsp_resp, rsp_timeout}, 32'h5);
    chk("t3 rdata", rsp_rdata, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    chk("t3 idle rready", {30'b0, rready, cmd_ready}, 32'h3);
    rvalid = 1; rdata = 32'h0000_0BAD;
    tick();
    slave_idle();
    chk("t3 drain", {30'b0, rsp_valid, cmd_ready}, 32'h1);
    chk("t3 drain rdata", rsp_rdata, 0);

    // SLVERR with response back-pressure
    cmd_valid = 1; cmd_rnw = 1; cmd_addr = 32'h44; arready = 1;
    tick();
    cmd_valid = 0;
    tick();
    arready = 0; rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b10;
    tick();
    for (int c = 0; c < 5; c++) begin
      rvalid = 1; rdata = 32'hFFFF_0000 + c; rresp = 2'b00; bvalid = 1;
      chk($sformatf("t4 h%0d ctl", c), {29'b0, rsp_valid, cmd_ready, rsp_timeout}, 32'h4);
      chk($sformatf("t4 h%0d data", c), rsp_rdata, 32'h1234_5678);
      chk($sformatf("t4 h%0d resp", c), {30'b0, rsp_resp}, 32'h2);
      tick();
    end
    slave_idle();
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // reset during WR_ADDR
    cmd_valid = 1; cmd_rnw = 0; cmd_addr = 32'h50; cmd_wdata = 32'h5555_AAAA;
    tick();
    cmd_valid = 0;
    chk("t5 awvalid", {31'b0, awvalid}, 1);
    rstn = 0;
    tick();
    chk("t5 valids", {28'b0, awvalid, wvalid, arvalid, rsp_valid}, 0);
    chk("t5 awaddr", awaddr, 0);
    rstn = 1;
    tick();
    chk("t5 idle", {30'b0, rsp_valid, cmd_ready}, 32'h1);

    // back-to-back reads
    addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
    idx = 0; nrsp = 0; overlap = 0; r_pend = 0; raddr = 0;
    arready = 1; rsp_ready = 1; cmd_rnw = 1;
    for (int c = 0; c < 40 && nrsp < 3; c++) begin
      cmd_valid = (idx < 3);
      cmd_addr = (idx < 3) ? addrs[idx] : 32'h0;
      rvalid = r_pend; rdata = r_pend ? 32'h1000 + raddr : 32'h0; rresp = 2'b00;
      if (arvalid && rsp_valid) overlap++;
      if (rsp_valid) begin
        chk($sformatf("t6 rsp%0d", nrsp), rsp_rdata, 32'h1000 + addrs[nrsp]);
        nrsp++;
      end
      acc = cmd_valid && cmd_ready; arh = arvalid && arready; rh = rvalid && rready;
      if (arh) raddr = araddr;
      tick();
      if (acc) idx++;
      if (rh) r_pend = 0;
      if (arh) r_pend = 1;
    end
    cmd_valid = 0;
    slave_idle();
    tick();
    chk("t6 count", nrsp, 3);
    chk("t6 overlap", overlap, 0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
